// File: rtl/sign_norm_pkg.sv
// Shared types and constants for the sign_normalizer block.
package sign_norm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned BYTE_STEP     = 8;
  localparam int unsigned SIGN_RUN_BITS = 9;

endpackage

// File: rtl/lead_sign_check.sv
// Combinational leading-sign inspection of the working word.
// SIGN_NORM_BYTE_STEP_EN enables the 9-bit sign-run detector; otherwise byte_ok_o is tied low.
module lead_sign_check
  import sign_norm_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] q_i,
  output logic             is_zero_o,
  output logic             byte_ok_o,
  output logic             bit_ok_o
);

`ifdef SIGN_NORM_BYTE_STEP_EN
  logic [SIGN_RUN_BITS-1:0] run;

  always_comb begin
    run       = q_i[WIDTH-1 -: SIGN_RUN_BITS];
    byte_ok_o = (run == '0) || (run == '1);
  end
`else
  always_comb begin
    byte_ok_o = 1'b0;
  end
`endif

  always_comb begin
    is_zero_o = (q_i == '0);
    bit_ok_o  = (q_i[WIDTH-1] == q_i[WIDTH-2]);
  end

endmodule

// File: rtl/sign_normalizer.sv
// Multi-cycle left-normalizer for signed words, reporting the shift count.
// SIGN_NORM_BYTE_STEP_EN adds 8-place steps; results are identical either way.
module sign_normalizer
  import sign_norm_pkg::*;
#(
  parameter  int WIDTH = 64,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero
);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             zero_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic is_zero;
  logic byte_ok;
  logic bit_ok;

  lead_sign_check #(
    .WIDTH(WIDTH)
  ) u_check (
    .q_i      (data_q),
    .is_zero_o(is_zero),
    .byte_ok_o(byte_ok),
    .bit_ok_o (bit_ok)
  );

  // A byte step is only taken when 9 sign bits match, so it equals 8 single steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            data_q     <= in_data;
            cnt_q      <= '0;
            zero_q     <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (is_zero) begin
            zero_q      <= 1'b1;
            cnt_q       <= CNT_W'(WIDTH);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (byte_ok) begin
            data_q <= data_q << BYTE_STEP;
            cnt_q  <= cnt_q + CNT_W'(BYTE_STEP);
          end else if (bit_ok) begin
            data_q <= data_q << 1;
            cnt_q  <= cnt_q + CNT_W'(1);
          end else begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = out_valid_q;
    out_data  = data_q;
    out_count = cnt_q;
    out_zero  = zero_q;
  end

endmodule

// File: tb/tb_sign_normalizer.sv
// Scoreboard bench for sign_normalizer; latency expectations follow SIGN_NORM_BYTE_STEP_EN.
module tb_sign_normalizer;

  localparam int W  = 64;
  localparam int CW = $clog2(W) + 1;

  typedef struct {
    logic [W-1:0]  data;
    logic [CW-1:0] cnt;
    logic          zero;
    int            lat;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_zero;

  exp_t sb[$];
  int   n_checks;
  int   n_pass;

  sign_normalizer #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count),
    .out_zero (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: one-place shifts only, independent of the step size used by the design.
  function automatic exp_t model(input logic [W-1:0] d);
    exp_t e;
    int   n;
    n      = 0;
    e.data = d;
    if (d == '0) begin
      e.cnt  = CW'(W);
      e.zero = 1'b1;
      e.lat  = 1;
    end else begin
      while (e.data[W-1] == e.data[W-2]) begin
        e.data = e.data << 1;
        n++;
      end
      e.cnt  = CW'(n);
      e.zero = 1'b0;
`ifdef SIGN_NORM_BYTE_STEP_EN
      e.lat  = n / 8 + n % 8 + 1;
`else
      e.lat  = n + 1;
`endif
    end
    return e;
  endfunction

  task automatic send(input logic [W-1:0] d);
    int w;
    w = 0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("send_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    sb.push_back(model(d));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   cyc;
    logic seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      seen = out_valid;
    end
    e = sb.pop_front();
    chk("out_valid_seen", {63'd0, seen}, 64'd1);
    if (!seen) return;
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("out_data", out_data, e.data);
    chk("out_count", {57'd0, out_count}, {57'd0, e.cnt});
    chk("out_zero", {63'd0, out_zero}, {63'd0, e.zero});
    if (!e.zero) chk("normalized", {63'd0, out_data[W-1] ^ out_data[W-2]}, 64'd1);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_data", out_data, e.data);
      chk("hold_count", {57'd0, out_count}, {57'd0, e.cnt});
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_valid", {63'd0, out_valid}, 64'd0);
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [W-1:0] vec[8];
    exp_t         dropped;
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_count", {57'd0, out_count}, 64'd0);
    chk("rst_out_zero", {63'd0, out_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vec[0] = 64'h4000_0000_0000_0000;
    vec[1] = 64'h0000_0000_0000_0001;
    vec[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    vec[3] = 64'h0000_0000_0000_0000;
    vec[4] = 64'h8000_0000_0000_0000;
    vec[5] = 64'hC000_0000_0000_0000;
    vec[6] = 64'hFFFF_FFF0_1234_5678;
    vec[7] = 64'h0000_0000_0000_00FF;
    foreach (vec[i]) begin
      send(vec[i]);
      collect(0);
    end
    repeat (6) begin
      send({$urandom, $urandom} >> $urandom_range(63, 0));
      collect(0);
    end

    // Hold the result while a second word waits on the input side.
    send(64'h4000_0000_0000_0000);
    @(negedge clk);
    in_data  = 64'h0000_0000_0000_00FF;
    in_valid = 1'b1;
    collect(5);
    @(posedge clk);
    sb.push_back(model(64'h0000_0000_0000_00FF));
    #1;
    chk("accept_next", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    collect(0);

    // Asynchronous reset while shifting.
    send(64'h0000_0000_0000_00FF);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    dropped = sb.pop_back();
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_out_data", out_data, 64'd0);
    chk("arst_out_count", {57'd0, out_count}, 64'd0);
    chk("arst_out_zero", {63'd0, out_zero}, 64'd0);
    chk("arst_dropped_cnt", {57'd0, dropped.cnt}, 64'd55);
    @(negedge clk);
    rst_n = 1'b1;
    send(64'h0000_0000_0000_00FF);
    collect(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
